// File: rtl/str_concat_stream_if.sv
// Bundles the request, character-stream and assembled-result signals of
// str_concat_stream. The master is the side that issues requests and
// consumes the stream. The slave is the concatenator itself.
interface str_concat_stream_if #(
  parameter int MAX_LEN = 8,
  parameter int CHAR_W  = 8
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int RLEN_W = $clog2(2 * MAX_LEN + 2);
  localparam int STR_W  = MAX_LEN * CHAR_W;
  localparam int RES_W  = (2 * MAX_LEN + 1) * CHAR_W;

  logic [STR_W-1:0]  str_a;
  logic [STR_W-1:0]  str_b;
  logic [LEN_W-1:0]  len_a;
  logic [LEN_W-1:0]  len_b;
  logic              sep_en;
  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] out_char;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [RES_W-1:0]  result;
  logic [RLEN_W-1:0] res_len;
  logic              result_valid;

  modport master (
    output str_a, str_b, len_a, len_b, sep_en, in_valid, out_ready,
    input  in_ready, out_char, out_valid, out_last, result, res_len, result_valid
  );

  modport slave (
    input  str_a, str_b, len_a, len_b, sep_en, in_valid, out_ready,
    output in_ready, out_char, out_valid, out_last, result, res_len, result_valid
  );
endinterface

// File: rtl/str_concat_stream.sv
// Sequential string concatenator. It streams str_a, an optional separator
// and str_b one character per beat. It also builds a right-justified packed
// copy of everything streamed, which can be printed with %s.
//
// Handshakes: a request transfers on a rising edge where in_valid && in_ready.
// A character transfers on a rising edge where out_valid && out_ready.
// out_char/out_valid/out_last are registered and do not change while
// out_valid && !out_ready. in_valid seen while in_ready=0 has no effect.
module str_concat_stream #(
  parameter int MAX_LEN = 8,
  parameter int CHAR_W  = 8,
  parameter logic [CHAR_W-1:0] SEP_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  str_concat_stream_if.slave   bus,
  output logic [2:0]           state_o
);
  localparam int LEN_W  = $clog2(MAX_LEN + 1);
  localparam int RLEN_W = $clog2(2 * MAX_LEN + 2);
  localparam int STR_W  = MAX_LEN * CHAR_W;
  localparam int RES_W  = (2 * MAX_LEN + 1) * CHAR_W;
  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EMIT_A   = 3'd1,
    EMIT_SEP = 3'd2,
    EMIT_B   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [STR_W-1:0]  a_q, b_q;
  logic [LEN_W-1:0]  la_q, lb_q;
  logic              sep_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic [CHAR_W-1:0] out_char_q;
  logic [RES_W-1:0]  result_q;
  logic [RLEN_W-1:0] res_len_q;
  logic              result_valid_q;

  logic              accept;
  logic              beat;
  logic [LEN_W-1:0]  la_clamp, lb_clamp;
  logic [STR_W-1:0]  src_a, src_b;
  logic [LEN_W-1:0]  src_la, src_lb;
  logic              src_sep;
  state_t            nxt_state;
  logic [LEN_W-1:0]  nxt_cnt;
  logic [CHAR_W-1:0] nxt_char;
  logic              nxt_last;

  assign accept   = (state_q == IDLE) && in_ready_q && bus.in_valid;
  assign beat     = out_valid_q && bus.out_ready;
  assign la_clamp = (bus.len_a > MAX_LEN_C) ? MAX_LEN_C : bus.len_a;
  assign lb_clamp = (bus.len_b > MAX_LEN_C) ? MAX_LEN_C : bus.len_b;

  // In the accept cycle the first beat comes straight from the inputs.
  // After that it comes from the captured copy.
  assign src_a   = accept ? bus.str_a : a_q;
  assign src_b   = accept ? bus.str_b : b_q;
  assign src_la  = accept ? la_clamp  : la_q;
  assign src_lb  = accept ? lb_clamp  : lb_q;
  assign src_sep = accept ? (bus.sep_en && (la_clamp != '0) && (lb_clamp != '0)) : sep_q;

  // Position of the next beat: skip empty phases, walk each string downward.
  always_comb begin
    nxt_state = state_q;
    nxt_cnt   = cnt_q;
    case (state_q)
      IDLE: begin
        if (src_la != '0) begin
          nxt_state = EMIT_A;
          nxt_cnt   = src_la - 1'b1;
        end else if (src_lb != '0) begin
          nxt_state = EMIT_B;
          nxt_cnt   = src_lb - 1'b1;
        end else begin
          nxt_state = DONE;
          nxt_cnt   = '0;
        end
      end
      EMIT_A: begin
        if (cnt_q != '0) begin
          nxt_cnt = cnt_q - 1'b1;
        end else if (src_sep) begin
          nxt_state = EMIT_SEP;
          nxt_cnt   = '0;
        end else if (src_lb != '0) begin
          nxt_state = EMIT_B;
          nxt_cnt   = src_lb - 1'b1;
        end else begin
          nxt_state = DONE;
        end
      end
      EMIT_SEP: begin
        nxt_state = EMIT_B;
        nxt_cnt   = src_lb - 1'b1;
      end
      EMIT_B: begin
        if (cnt_q != '0) nxt_cnt = cnt_q - 1'b1;
        else             nxt_state = DONE;
      end
      default: begin
        nxt_state = DONE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Character and last-flag of the beat at the next position.
  always_comb begin
    nxt_char = '0;
    nxt_last = 1'b0;
    case (nxt_state)
      EMIT_A: begin
        nxt_char = src_a[nxt_cnt*CHAR_W +: CHAR_W];
        nxt_last = (nxt_cnt == '0) && !src_sep && (src_lb == '0);
      end
      EMIT_SEP: nxt_char = SEP_CHAR;
      EMIT_B: begin
        nxt_char = src_b[nxt_cnt*CHAR_W +: CHAR_W];
        nxt_last = (nxt_cnt == '0);
      end
      default: begin
        nxt_char = '0;
        nxt_last = 1'b0;
      end
    endcase
  end

  // Main FSM: request capture, beat sequencing, result assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      a_q            <= '0;
      b_q            <= '0;
      la_q           <= '0;
      lb_q           <= '0;
      sep_q          <= 1'b0;
      in_ready_q     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      out_char_q     <= '0;
      result_q       <= '0;
      res_len_q      <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          result_valid_q <= 1'b0;
          if (accept) begin
            a_q        <= bus.str_a;
            b_q        <= bus.str_b;
            la_q       <= la_clamp;
            lb_q       <= lb_clamp;
            sep_q      <= src_sep;
            result_q   <= '0;
            res_len_q  <= '0;
            in_ready_q <= 1'b0;
            state_q    <= nxt_state;
            cnt_q      <= nxt_cnt;
            if (nxt_state == DONE) begin
              result_valid_q <= 1'b1;
              out_valid_q    <= 1'b0;
            end else begin
              out_valid_q <= 1'b1;
              out_char_q  <= nxt_char;
              out_last_q  <= nxt_last;
            end
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        EMIT_A, EMIT_SEP, EMIT_B: begin
          if (beat) begin
            result_q  <= {result_q[RES_W-CHAR_W-1:0], out_char_q};
            res_len_q <= res_len_q + 1'b1;
            state_q   <= nxt_state;
            cnt_q     <= nxt_cnt;
            if (nxt_state == DONE) begin
              out_valid_q    <= 1'b0;
              out_last_q     <= 1'b0;
              out_char_q     <= '0;
              result_valid_q <= 1'b1;
            end else begin
              out_char_q <= nxt_char;
              out_last_q <= nxt_last;
            end
          end
        end
        DONE: begin
          result_valid_q <= 1'b0;
          in_ready_q     <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.out_char     = out_char_q;
  assign bus.result       = result_q;
  assign bus.res_len      = res_len_q;
  assign bus.result_valid = result_valid_q;
  assign state_o          = state_q;
endmodule

// File: tb/tb_str_concat_stream.sv
// Directed bench for str_concat_stream. It uses a table of requests with
// hand-written expected strings. A queue of expected characters is checked
// beat by beat. Hand-written sequences cover stalls, back-to-back requests
// and reset during a stream.
module tb_str_concat_stream;
  localparam int MAX_LEN = 8;
  localparam int CHAR_W  = 8;
  localparam int STR_W   = MAX_LEN * CHAR_W;
  localparam int RES_W   = (2 * MAX_LEN + 1) * CHAR_W;
  localparam int NVEC    = 8;

  typedef struct {
    logic [STR_W-1:0] a;
    logic [STR_W-1:0] b;
    logic [3:0]       la;
    logic [3:0]       lb;
    logic             sep;
    logic [RES_W-1:0] exp;
    int               exp_len;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0] state_o;
  str_concat_stream_if #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W)) bus ();

  str_concat_stream #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .SEP_CHAR(8'h20)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state_o)
  );

  int checks = 0;
  int errors = 0;
  logic [CHAR_W-1:0] exp_q[$];
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // driver tasks
  task automatic drive_vec(input int i);
    bus.str_a    = vecs[i].a;
    bus.str_b    = vecs[i].b;
    bus.len_a    = vecs[i].la;
    bus.len_b    = vecs[i].lb;
    bus.sep_en   = vecs[i].sep;
    bus.in_valid = 1'b1;
  endtask

  task automatic scramble_inputs();
    bus.in_valid = 1'b0;
    bus.str_a    = {$urandom, $urandom};
    bus.str_b    = {$urandom, $urandom};
    bus.len_a    = 4'($urandom_range(0, 15));
    bus.len_b    = 4'($urandom_range(0, 15));
    bus.sep_en   = 1'($urandom_range(0, 1));
  endtask

  // Runs one request. mode 0: out_ready always high; mode 1: ready 1,0,0,...
  // hold_next >= 0 keeps in_valid high with that vector after acceptance.
  // predriven: the request is already on the bus and in_ready is high.
  task automatic run_vec(input int i, input int mode, input int hold_next, input bit predriven);
    int n;
    int cyc;
    bit done;
    bit prev_stall;
    logic [CHAR_W-1:0] prev_char;
    logic prev_last;
    logic [CHAR_W-1:0] c;
    exp_q.delete();
    for (int k = 0; k < vecs[i].exp_len; k++)
      exp_q.push_back(vecs[i].exp[(vecs[i].exp_len - 1 - k) * CHAR_W +: CHAR_W]);
    if (!predriven) begin
      @(negedge clk);
      n = 0;
      while (!bus.in_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready) begin
        fail("idle_timeout");
        return;
      end
      drive_vec(i);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_drop", bus.in_ready, 0);
    if (hold_next >= 0) drive_vec(hold_next);
    else scramble_inputs();
    cyc = 0;
    done = 1'b0;
    prev_stall = 1'b0;
    prev_char = '0;
    prev_last = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      bus.out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (cyc == 0) check("first_valid", bus.out_valid, vecs[i].exp_len > 0);
      if (prev_stall) begin
        check("stall_char", bus.out_char, prev_char);
        check("stall_last", bus.out_last, prev_last);
      end
      if (bus.result_valid) begin
        done = 1'b1;
        check("result", bus.result, vecs[i].exp);
        check("res_len", bus.res_len, vecs[i].exp_len);
        check("beats_left", exp_q.size(), 0);
        check("valid_in_done", bus.out_valid, 0);
        if (mode == 0) check("latency", cyc, vecs[i].exp_len);
      end else if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          fail("extra_beat");
        end else begin
          c = exp_q.pop_front();
          check("char", bus.out_char, c);
          check("last", bus.out_last, exp_q.size() == 0);
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_char  = bus.out_char;
      prev_last  = bus.out_last;
      cyc++;
    end
    if (!done) fail("rv_timeout");
    @(negedge clk);
    check("rv_pulse", bus.result_valid, 0);
    check("in_ready_back", bus.in_ready, 1);
    check("result_hold", bus.result, vecs[i].exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: "Hello,", b: "World!", la: 4'd6, lb: 4'd6, sep: 1'b1,
                exp: "Hello, World!", exp_len: 13};
    vecs[1] = '{a: "Hello,  ", b: "World!", la: 4'd8, lb: 4'd6, sep: 1'b0,
                exp: "Hello,  World!", exp_len: 14};
    vecs[2] = '{a: '0, b: "abc", la: 4'd0, lb: 4'd3, sep: 1'b1,
                exp: "abc", exp_len: 3};
    vecs[3] = '{a: '0, b: '0, la: 4'd0, lb: 4'd0, sep: 1'b1,
                exp: '0, exp_len: 0};
    vecs[4] = '{a: "ABCDEFGH", b: "xy", la: 4'd12, lb: 4'd2, sep: 1'b0,
                exp: "ABCDEFGHxy", exp_len: 10};
    vecs[5] = '{a: "ABCDEFGH", b: "12345678", la: 4'd12, lb: 4'd15, sep: 1'b1,
                exp: "ABCDEFGH 12345678", exp_len: 17};
    vecs[6] = '{a: "abcdef", b: "ghij", la: 4'd3, lb: 4'd2, sep: 1'b1,
                exp: "def ij", exp_len: 6};
    vecs[7] = '{a: "abc", b: '0, la: 4'd3, lb: 4'd0, sep: 1'b1,
                exp: "abc", exp_len: 3};

    bus.str_a = '0;
    bus.str_b = '0;
    bus.len_a = '0;
    bus.len_b = '0;
    bus.sep_en = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;

    // reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_char", bus.out_char, 0);
    check("rst_result", bus.result, 0);
    check("rst_res_len", bus.res_len, 0);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_state", state_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready_low", bus.in_ready, 0);
    @(posedge clk);
    #1 check("rel_in_ready_high", bus.in_ready, 1);

    // table-driven pass with out_ready held high
    for (int i = 0; i < NVEC; i++) run_vec(i, 0, -1, 1'b0);

    // stalled stream
    run_vec(0, 1, -1, 1'b0);
    run_vec(1, 1, -1, 1'b0);

    // back-to-back with in_valid held high
    run_vec(4, 0, 5, 1'b0);
    run_vec(5, 0, 3, 1'b1);
    run_vec(3, 0, -1, 1'b1);

    // reset during the 4th beat
    @(negedge clk);
    drive_vec(0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 scramble_inputs();
    repeat (4) @(negedge clk);
    check("rst_pre_char", bus.out_char, 8'h6c);
    check("rst_pre_result", bus.result, 24'h48656c);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_out_char", bus.out_char, 0);
    check("mid_rst_out_last", bus.out_last, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    check("mid_rst_result", bus.result, 0);
    check("mid_rst_res_len", bus.res_len, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("mid_rst_no_rv", bus.result_valid, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_no_rv", bus.result_valid, 0);
    end
    run_vec(6, 0, -1, 1'b0);
    run_vec(0, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/str_concat_stream.md
# str_concat_stream

Parametrised, sequential string concatenator. It accepts two Verilog-packed strings with explicit character counts and an optional separator. It emits the joined string one character per beat on a valid/ready stream, and also assembles a right-justified packed result suitable for `%s` display. Embedded leading NUL padding of either operand never appears in the output. The block sits between string producers (message formatters, test-message ROMs) and byte-serial consumers such as a UART TX or display driver.

## Interface
- `MAX_LEN`, 8: maximum characters per input string.
- `CHAR_W`, 8: bits per character.
- `SEP_CHAR`, 8'h20: separator character inserted when `sep_en`=1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `str_a`, `str_b`  in  MAX_LEN*CHAR_W  each  packed strings; last character in bits [CHAR_W-1:0], first character at byte len-1.
- `len_a`, `len_b`  in  $clog2(MAX_LEN+1)  each  character counts; values > MAX_LEN clamp to MAX_LEN.
- `sep_en`  in  1  insert SEP_CHAR between the two strings.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block idle, can accept.
- `out_char`  out  CHAR_W  current stream character.
- `out_valid`  out  1  `out_char` valid.
- `out_ready`  in  1  consumer accepts `out_char`.
- `out_last`  out  1  `out_char` is the final character.
- `result`  out  (2*MAX_LEN+1)*CHAR_W  packed concatenation, right-justified, zero-filled above.
- `res_len`  out  $clog2(2*MAX_LEN+2)  characters in `result`.
- `result_valid`  out  1  one-cycle pulse: `result`/`res_len` final.

## Operation
- FSM states: IDLE, EMIT_A, EMIT_SEP, EMIT_B, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: capture `str_a`, `str_b`, clamped lengths and `sep_en`; clear `result` and `res_len`.
  - Next state is the first non-empty phase in the order EMIT_A, EMIT_SEP, EMIT_B. If all phases are empty, go to DONE.
- Separator phase is active only when `sep_en`=1, `len_a`>0 and `len_b`>0.
- EMIT_A walks a down-counter from `len_a`-1 to 0. `out_char` = `str_a` byte[counter]. EMIT_B does the same on `str_b`. EMIT_SEP emits one beat of SEP_CHAR.
- Beat advance happens only on `out_valid`&&`out_ready`. On each handshake:
  - `result` <= {`result` shifted left CHAR_W, `out_char`}.
  - `res_len` += 1.
  - The counter and phase advance.
- `out_last`=1 on the beat with no further characters in any remaining phase.
- After the last handshake, go to DONE. DONE lasts one cycle: `result_valid`=1. Then return to IDLE.
- `result` and `res_len` hold their values until the next accept.
- Total length is `len_a` + `len_b` + sep, with a maximum of 2*MAX_LEN+1. The shift never overflows `result`.

## Timing
- Reset (async assert): state IDLE.
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `out_char`=0, `result`=0, `res_len`=0, `result_valid`=0.
  - `in_ready` rises on the first rising edge after `rst_n` deasserts.
- Accept at edge T: `in_ready` drops at T. The first `out_valid` is high in the cycle after T.
- Output stream:
  - `out_char`, `out_valid` and `out_last` are registered and stable while `out_valid`&&!`out_ready`.
  - With `out_ready` held high, N characters take N consecutive cycles.
  - `result_valid` pulses in the cycle after the last handshake. `in_ready` returns the cycle after that.
- Zero total length: no beats, `out_valid` never rises. `result_valid` pulses the cycle after accept, with `result`=0 and `res_len`=0.
- Throughput: N+2 cycles per request, so back-to-back requests are accepted every N+2 cycles.
- `in_valid` while `in_ready`=0 is ignored. Inputs need only be stable in the accept cycle.
- `rst_n` asserted mid-stream: all state aborts immediately. No `result_valid` follows, and the partial `result` is cleared.

## Test plan
- str_a="Hello,", len_a=6, str_b="World!", len_b=6, sep_en=1, `out_ready`=1 -> 13 beats "Hello, World!". `out_last` on '!'. `result` displays "Hello, World!", `res_len`=13, `result_valid` exactly one cycle.
- str_a="Hello,  " (len_a=8), str_b="World!" (len_b=6, leading NULs), sep_en=0 -> no NUL beats. `result`="Hello,  World!", `res_len`=14.
- Same request as the first scenario with `out_ready` toggling 1,0,0,1,... -> every character is held stable while stalled. The sequence is unchanged, with no drops and no duplicates.
- len_a=0, len_b=3 "abc", sep_en=1 -> no separator, 3 beats. Then len_a=0, len_b=0 -> zero beats, `result_valid` the cycle after accept, `res_len`=0.
- len_a=12 (MAX_LEN=8) -> clamped to 8 characters. Two back-to-back requests with `in_valid` held high -> the second is accepted exactly when `in_ready` returns, and both results are correct.
- `rst_n` pulsed low during the 4th beat -> all outputs 0 immediately, no `result_valid`. A new request after release completes normally.
